mc_cu: RTL and testbench

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_pkg.sv | 97 +++++++++
 rtl/mc_cu_if.sv | 32 +++
 rtl/mc_decode.sv | 35 +++
 rtl/mc_cu.sv | 114 +++++++++++
 tb/tb_mc_cu.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_cu shared definitions: FSM states, opcode/func fields,
// ALU and mux select codes, instruction class bundle.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] A_PC = 2'b00;
  localparam logic [1:0] A_RS = 2'b01;
  localparam logic [1:0] A_SA = 2'b10;

  localparam logic [1:0] B_RT  = 2'b00;
  localparam logic [1:0] B_4   = 2'b01;
  localparam logic [1:0] B_IMM = 2'b10;
  localparam logic [1:0] B_BR  = 2'b11;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_REG = 2'b01;
  localparam logic [1:0] PC_RS  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  typedef struct packed {
    logic r_alu;
    logic shift;
    logic jr;
    logic i_alu;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic bad;
  } cls_t;

  function automatic logic [3:0] alu_r(input logic [5:0] f);
    case (f)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_XOR:   return ALU_XOR;
      F_SLL:   return ALU_SLL;
      F_SRL:   return ALU_SRL;
      F_SRA:   return ALU_SRA;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] alu_i(input logic [5:0] o);
    case (o)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_cu_if.sv
// Instruction fields in, datapath control strobes out.
// master = control unit side, slave = datapath side.
interface mc_cu_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       wpc;
  logic       wir;
  logic       wmem;
  logic       wreg;
  logic       iord;
  logic       regrt;
  logic       m2reg;
  logic       jal;
  logic       sext;
  logic [3:0] aluc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;

  modport master (
    input  op, func, z,
    output wpc, wir, wmem, wreg, iord, regrt, m2reg,
    output jal, sext, aluc, alusrca, alusrcb, pcsource
  );

  modport slave (
    output op, func, z,
    input  wpc, wir, wmem, wreg, iord, regrt, m2reg,
    input  jal, sext, aluc, alusrca, alusrcb, pcsource
  );
endinterface

// File: rtl/mc_decode.sv
// op/func to one-hot instruction class; anything
// unrecognised lands in the bad class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output cls_t       cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_R: begin
        case (func)
          F_ADD, F_SUB, F_AND,
          F_OR, F_XOR:         cls.r_alu = 1'b1;
          F_SLL, F_SRL, F_SRA: cls.shift = 1'b1;
          F_JR:                cls.jr    = 1'b1;
          default:             cls.bad   = 1'b1;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI,
      OP_XORI, OP_LUI:  cls.i_alu = 1'b1;
      OP_LW:            cls.lw    = 1'b1;
      OP_SW:            cls.sw    = 1'b1;
      OP_BEQ:           cls.beq   = 1'b1;
      OP_BNE:           cls.bne   = 1'b1;
      OP_J:             cls.j     = 1'b1;
      OP_JAL:           cls.jal   = 1'b1;
      default:          cls.bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_cu.sv
// Multicycle control unit: five-state FSM, outputs decoded
// combinationally from state and the live op/func/z.
module mc_cu
  import mc_pkg::*;
(
  input  logic clock,
  input  logic reset,
  mc_cu_if.master bus
);

  state_t state, nxt;
  cls_t   c;

  mc_decode u_dec (
    .op   (bus.op),
    .func (bus.func),
    .cls  (c)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IF;
    else       state <= nxt;
  end

  always_comb begin
    nxt          = S_IF;
    bus.wpc      = 1'b0;
    bus.wir      = 1'b0;
    bus.wmem     = 1'b0;
    bus.wreg     = 1'b0;
    bus.iord     = 1'b0;
    bus.regrt    = 1'b0;
    bus.m2reg    = 1'b0;
    bus.jal      = 1'b0;
    bus.sext     = 1'b0;
    bus.aluc     = ALU_ADD;
    bus.alusrca  = A_PC;
    bus.alusrcb  = B_RT;
    bus.pcsource = PC_ALU;
    unique case (state)
      S_IF: begin
        bus.wpc     = 1'b1;
        bus.wir     = 1'b1;
        bus.alusrcb = B_4;
        nxt         = S_ID;
      end
      S_ID: begin
        if (c.j | c.jal | c.jr) begin
          bus.wpc      = 1'b1;
          bus.pcsource = c.jr ? PC_RS : PC_JMP;
          bus.wreg     = c.jal;
          bus.jal      = c.jal;
        end else if (!c.bad) begin
          // precompute branch target into the ALU result register
          bus.alusrcb = B_BR;
          bus.sext    = 1'b1;
          nxt         = S_EXE;
        end
      end
      S_EXE: begin
        unique case (1'b1)
          c.beq, c.bne: begin
            bus.alusrca  = A_RS;
            bus.aluc     = ALU_SUB;
            bus.pcsource = PC_REG;
            bus.wpc      = (c.beq & bus.z) | (c.bne & ~bus.z);
          end
          c.lw, c.sw: begin
            bus.alusrca = A_RS;
            bus.alusrcb = B_IMM;
            bus.sext    = 1'b1;
            nxt         = S_MEM;
          end
          c.r_alu, c.shift: begin
            bus.alusrca = c.shift ? A_SA : A_RS;
            bus.aluc    = alu_r(bus.func);
            nxt         = S_WB;
          end
          c.i_alu: begin
            bus.alusrca = A_RS;
            bus.alusrcb = B_IMM;
            bus.sext    = (bus.op == OP_ADDI);
            bus.aluc    = alu_i(bus.op);
            nxt         = S_WB;
          end
          default: nxt = S_IF;
        endcase
      end
      S_MEM: begin
        if (c.lw) begin
          bus.iord = 1'b1;
          nxt      = S_WB;
        end else if (c.sw) begin
          bus.iord = 1'b1;
          bus.wmem = 1'b1;
        end
      end
      S_WB: begin
        bus.wreg  = 1'b1;
        bus.regrt = c.i_alu | c.lw;
        bus.m2reg = c.lw;
      end
      default: nxt = S_IF;
    endcase
    if (reset) begin
      bus.wpc  = 1'b0;
      bus.wir  = 1'b0;
      bus.wmem = 1'b0;
      bus.wreg = 1'b0;
      nxt      = S_IF;
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// Directed-vector bench for mc_cu: per-cycle control word
// checked against hand-computed values.
module tb_mc_cu;

  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  mc_cu_if bus ();

  mc_cu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // {wpc,wir,wmem,wreg,iord,regrt,m2reg,jal,sext,aluc,asa,asb,pcs}
  logic [18:0] outs;
  assign outs = {bus.wpc, bus.wir, bus.wmem, bus.wreg, bus.iord,
                 bus.regrt, bus.m2reg, bus.jal, bus.sext, bus.aluc,
                 bus.alusrca, bus.alusrcb, bus.pcsource};

  function automatic logic [18:0] cw(
    input logic       wpc, wir, wmem, wreg, iord,
    input logic       regrt, m2reg, jal, sext,
    input logic [3:0] aluc,
    input logic [1:0] asa, asb, pcs
  );
    return {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext,
            aluc, asa, asb, pcs};
  endfunction

  task automatic chk(input string tag, input logic [18:0] got,
                     input logic [18:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h want %05h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ins(input logic [5:0] o, input logic [5:0] f,
                         input logic zz);
    bus.op   = o;
    bus.func = f;
    bus.z    = zz;
  endtask

  logic [18:0] w_if, w_id, w_zero;

  initial begin
    w_if   = cw(1,1,0,0,0,0,0,0,0,4'b0000,2'b00,2'b01,2'b00);
    w_id   = cw(0,0,0,0,0,0,0,0,1,4'b0000,2'b00,2'b11,2'b00);
    w_zero = '0;

    reset = 1'b1;
    set_ins(6'h08, 6'h00, 1'b0);
    tick(); tick();
    chk("rst_if", outs, cw(0,0,0,0,0,0,0,0,0,4'b0000,2'b00,2'b01,2'b00));
    reset = 1'b0; #1;
    chk("addi_if", outs, w_if);
    tick(); chk("addi_id", outs, w_id);
    tick(); chk("addi_exe", outs,
                cw(0,0,0,0,0,0,0,0,1,4'b0000,2'b01,2'b10,2'b00));
    tick(); chk("addi_wb", outs,
                cw(0,0,0,1,0,1,0,0,0,4'b0000,2'b00,2'b00,2'b00));
    tick(); chk("addi_ret", outs, w_if);

    set_ins(6'h23, 6'h00, 1'b0);
    tick(); chk("lw_id", outs, w_id);
    tick(); chk("lw_exe", outs,
                cw(0,0,0,0,0,0,0,0,1,4'b0000,2'b01,2'b10,2'b00));
    tick(); chk("lw_mem", outs,
                cw(0,0,0,0,1,0,0,0,0,4'b0000,2'b00,2'b00,2'b00));
    tick(); chk("lw_wb", outs,
                cw(0,0,0,1,0,1,1,0,0,4'b0000,2'b00,2'b00,2'b00));
    tick(); chk("lw_ret", outs, w_if);

    set_ins(6'h2b, 6'h00, 1'b0);
    tick(); chk("sw_id", outs, w_id);
    tick(); chk("sw_exe", outs,
                cw(0,0,0,0,0,0,0,0,1,4'b0000,2'b01,2'b10,2'b00));
    tick(); chk("sw_mem", outs,
                cw(0,0,1,0,1,0,0,0,0,4'b0000,2'b00,2'b00,2'b00));
    tick(); chk("sw_ret", outs, w_if);

    for (int k = 0; k < 4; k++) begin
      set_ins(k[1] ? 6'h05 : 6'h04, 6'h00, k[0]);
      tick(); chk("br_id", outs, w_id);
      // taken: beq with z=1 (k=1), bne with z=0 (k=2)
      tick(); chk("br_exe", outs,
                  cw(k[1] ^ k[0],0,0,0,0,0,0,0,0,4'b0100,
                     2'b01,2'b00,2'b01));
      tick(); chk("br_ret", outs, w_if);
    end

    set_ins(6'h03, 6'h00, 1'b0);
    tick(); chk("jal_id", outs,
                cw(1,0,0,1,0,0,0,1,0,4'b0000,2'b00,2'b00,2'b11));
    tick(); chk("jal_ret", outs, w_if);

    set_ins(6'h02, 6'h00, 1'b0);
    tick(); chk("j_id", outs,
                cw(1,0,0,0,0,0,0,0,0,4'b0000,2'b00,2'b00,2'b11));
    tick(); chk("j_ret", outs, w_if);

    set_ins(6'h00, 6'h08, 1'b0);
    tick(); chk("jr_id", outs,
                cw(1,0,0,0,0,0,0,0,0,4'b0000,2'b00,2'b00,2'b10));
    tick(); chk("jr_ret", outs, w_if);

    set_ins(6'h00, 6'h03, 1'b0);
    tick(); chk("sra_id", outs, w_id);
    tick(); chk("sra_exe", outs,
                cw(0,0,0,0,0,0,0,0,0,4'b1111,2'b10,2'b00,2'b00));
    tick(); chk("sra_wb", outs,
                cw(0,0,0,1,0,0,0,0,0,4'b0000,2'b00,2'b00,2'b00));
    tick(); chk("sra_ret", outs, w_if);

    set_ins(6'h00, 6'h22, 1'b0);
    tick(); tick(); chk("sub_exe", outs,
                cw(0,0,0,0,0,0,0,0,0,4'b0100,2'b01,2'b00,2'b00));
    tick(); tick(); chk("sub_ret", outs, w_if);

    set_ins(6'h0d, 6'h00, 1'b0);
    tick(); tick(); chk("ori_exe", outs,
                cw(0,0,0,0,0,0,0,0,0,4'b0101,2'b01,2'b10,2'b00));
    tick(); chk("ori_wb", outs,
                cw(0,0,0,1,0,1,0,0,0,4'b0000,2'b00,2'b00,2'b00));
    tick();

    set_ins(6'h0f, 6'h00, 1'b0);
    tick(); tick(); chk("lui_exe", outs,
                cw(0,0,0,0,0,0,0,0,0,4'b0110,2'b01,2'b10,2'b00));
    tick(); tick(); chk("lui_ret", outs, w_if);

    set_ins(6'h3f, 6'h00, 1'b0);
    tick(); chk("bad_op_id", outs, w_zero);
    tick(); chk("bad_op_ret", outs, w_if);

    set_ins(6'h00, 6'h3f, 1'b0);
    tick(); chk("bad_fn_id", outs, w_zero);
    tick(); chk("bad_fn_ret", outs, w_if);

    set_ins(6'h2b, 6'h00, 1'b0);
    tick(); tick(); tick();
    chk("rsw_mem", outs,
        cw(0,0,1,0,1,0,0,0,0,4'b0000,2'b00,2'b00,2'b00));
    reset = 1'b1; #1;
    chk("rsw_mem_rst", outs,
        cw(0,0,0,0,1,0,0,0,0,4'b0000,2'b00,2'b00,2'b00));
    tick(); reset = 1'b0; #1;
    chk("rsw_if", outs, w_if);
    tick(); chk("rsw_id", outs, w_id);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
